// File: rtl/cmp4_pkg.sv
// Shared types and helpers for the 4-operand comparator frame loader.
// Holds the FSM state type, the operand index constants and the flag-vector helpers.
package cmp4_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;
    localparam logic [1:0] IDX_D = 2'd3;

    // An empty vector maps to IDX_A so the index output is always defined.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = IDX_A;
        if (v[0])      idx = IDX_A;
        else if (v[1]) idx = IDX_B;
        else if (v[2]) idx = IDX_C;
        else if (v[3]) idx = IDX_D;
        return idx;
    endfunction

    function automatic logic multi_set(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/cmp4_frame_loader_if.sv
// Word-stream input and result output of the frame loader.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid and ready are
// both high; the source holds data stable while valid is high and ready is low.
interface cmp4_frame_loader_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in_data_21;
    logic             in_valid_21;
    logic             in_ready_21;
    logic             res_valid_21;
    logic             res_ready_21;
    logic [1:0]       max_idx_21;
    logic [1:0]       min_idx_21;
    logic             max_tie_21;
    logic             min_tie_21;
    logic             cmp_err_21;
    logic [3:0]       gte_q_21;
    logic [3:0]       lte_q_21;
    logic [CNT_W-1:0] frames_21;

    // master: the environment feeding words and consuming results
    modport master (
        output in_data_21, in_valid_21, res_ready_21,
        input  in_ready_21, res_valid_21, max_idx_21, min_idx_21, max_tie_21, min_tie_21,
               cmp_err_21, gte_q_21, lte_q_21, frames_21
    );

    // slave: the frame loader itself
    modport slave (
        input  in_data_21, in_valid_21, res_ready_21,
        output in_ready_21, res_valid_21, max_idx_21, min_idx_21, max_tie_21, min_tie_21,
               cmp_err_21, gte_q_21, lte_q_21, frames_21
    );
endinterface

// File: rtl/cmp4_flag_encoder.sv
// Combinational encoding of the comparator GTE/LTE vectors into indices, tie and error flags.
// The parent registers these at capture time.
module cmp4_flag_encoder
    import cmp4_pkg::*;
(
    input  logic [3:0] gte,
    input  logic [3:0] lte,
    output logic [1:0] max_idx,
    output logic [1:0] min_idx,
    output logic       max_tie,
    output logic       min_tie,
    output logic       cmp_err
);

    assign max_idx = lowest_set(gte);
    assign min_idx = lowest_set(lte);
    assign max_tie = multi_set(gte);
    assign min_tie = multi_set(lte);
    // A healthy comparator always flags at least one max and one min.
    assign cmp_err = (gte == 4'd0) || (lte == 4'd0);

endmodule

// File: rtl/cmp4_frame_loader.sv
// Packs four stream words into operands A..D, waits SETTLE cycles (legal 1..15) for the external
// comparator, captures its encoded flags and offers them on the result handshake.
module cmp4_frame_loader
    import cmp4_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk_21,
    input  logic             rst_21,
    input  logic             flush_21,
    cmp4_frame_loader_if.slave bus,
    output logic [WIDTH-1:0] A_21,
    output logic [WIDTH-1:0] B_21,
    output logic [WIDTH-1:0] C_21,
    output logic [WIDTH-1:0] D_21,
    input  logic [3:0]       gte_21,
    input  logic [3:0]       lte_21,
    output state_t           state_21
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state;
    logic [1:0]       word_cnt;
    logic [3:0]       settle_cnt;
    logic             res_valid;
    logic [1:0]       max_idx_q;
    logic [1:0]       min_idx_q;
    logic             max_tie_q;
    logic             min_tie_q;
    logic             cmp_err_q;
    logic [3:0]       gte_q;
    logic [3:0]       lte_q;
    logic [CNT_W-1:0] frames;

    logic [1:0] enc_max_idx;
    logic [1:0] enc_min_idx;
    logic       enc_max_tie;
    logic       enc_min_tie;
    logic       enc_cmp_err;
    logic       in_ready;
    logic       in_xfer;
    logic       res_xfer;

    cmp4_flag_encoder u_enc (
        .gte     (gte_21),
        .lte     (lte_21),
        .max_idx (enc_max_idx),
        .min_idx (enc_min_idx),
        .max_tie (enc_max_tie),
        .min_tie (enc_min_tie),
        .cmp_err (enc_cmp_err)
    );

    // Gated by reset directly so ready is low during reset and high right after release.
    assign in_ready = (state == LOAD) && !rst_21;
    assign in_xfer  = bus.in_valid_21 && in_ready;
    assign res_xfer = res_valid && bus.res_ready_21;

    always_ff @(posedge clk_21) begin
        if (rst_21) begin
            state      <= LOAD;
            word_cnt   <= 2'd0;
            settle_cnt <= 4'd0;
            A_21       <= '0;
            B_21       <= '0;
            C_21       <= '0;
            D_21       <= '0;
            res_valid  <= 1'b0;
            max_idx_q  <= 2'd0;
            min_idx_q  <= 2'd0;
            max_tie_q  <= 1'b0;
            min_tie_q  <= 1'b0;
            cmp_err_q  <= 1'b0;
            gte_q      <= 4'd0;
            lte_q      <= 4'd0;
            frames     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    // Flush beats a coincident word: the word is dropped, operands are kept.
                    if (flush_21) begin
                        word_cnt <= 2'd0;
                    end else if (in_xfer) begin
                        case (word_cnt)
                            IDX_A:   A_21 <= bus.in_data_21;
                            IDX_B:   B_21 <= bus.in_data_21;
                            IDX_C:   C_21 <= bus.in_data_21;
                            default: D_21 <= bus.in_data_21;
                        endcase
                        if (word_cnt == IDX_D) begin
                            word_cnt   <= 2'd0;
                            settle_cnt <= 4'd0;
                            state      <= SAMPLE;
                        end else begin
                            word_cnt <= word_cnt + 2'd1;
                        end
                    end
                end
                SAMPLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        gte_q     <= gte_21;
                        lte_q     <= lte_21;
                        max_idx_q <= enc_max_idx;
                        min_idx_q <= enc_min_idx;
                        max_tie_q <= enc_max_tie;
                        min_tie_q <= enc_min_tie;
                        cmp_err_q <= enc_cmp_err;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (res_xfer) begin
                        frames    <= frames + CNT_W'(1);
                        res_valid <= 1'b0;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.in_ready_21  = in_ready;
    assign bus.res_valid_21 = res_valid;
    assign bus.max_idx_21   = max_idx_q;
    assign bus.min_idx_21   = min_idx_q;
    assign bus.max_tie_21   = max_tie_q;
    assign bus.min_tie_21   = min_tie_q;
    assign bus.cmp_err_21   = cmp_err_q;
    assign bus.gte_q_21     = gte_q;
    assign bus.lte_q_21     = lte_q;
    assign bus.frames_21    = frames;
    assign state_21         = state;

endmodule
